// File: rtl/bridge_resp_target.sv
`default_nettype none
// ============================================================================
//  Module   : bridge_resp_target
//  Purpose  : Target-side end of the bridge req/gnt protocol. Forwards a single
//             arbitrated request stream to a variable-latency slave port. It
//             tracks outstanding requester IDs in order and produces the
//             push-style response (r_valid / r_ID / r_rdata).
//  Revision : 1.0 - initial release
// ============================================================================
module bridge_resp_target #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int ID_WIDTH        = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  // request side (from the arbitrated initiator stream)
  input  logic                                   data_req_i,
  input  logic [ADDR_WIDTH-1:0]                  data_add_i,
  input  logic                                   data_wen_i,
  input  logic [DATA_WIDTH-1:0]                  data_wdata_i,
  input  logic [BE_WIDTH-1:0]                    data_be_i,
  input  logic [ID_WIDTH-1:0]                    data_ID_i,
  output logic                                   data_gnt_o,
  // response side (push-style, no back-pressure)
  output logic                                   data_r_valid_o,
  output logic [ID_WIDTH-1:0]                    data_r_ID_o,
  output logic [DATA_WIDTH-1:0]                  data_r_rdata_o,
  // slave port
  output logic                                   mem_req_o,
  output logic [ADDR_WIDTH-1:0]                  mem_add_o,
  output logic                                   mem_wen_o,
  output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
  output logic [BE_WIDTH-1:0]                    mem_be_o,
  input  logic                                   mem_gnt_i,
  input  logic                                   mem_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                  mem_r_rdata_i,
  // status
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   err_o
);

  localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(MAX_OUTSTANDING);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(MAX_OUTSTANDING - 1);

  // In-order ID tracking storage and its bookkeeping
  logic [ID_WIDTH-1:0]   r_id_fifo [MAX_OUTSTANDING];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;

  // Registered response and sticky error
  logic                  r_rsp_valid;
  logic [ID_WIDTH-1:0]   r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_err;

  logic [c_CNT_W-1:0]    w_count_eff;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_gnt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_spurious;

  // Full decision from the registered count only, so gnt never depends on the
  // same-cycle response. While rst is asserted the count is treated as zero.
  always_comb begin
    w_count_eff = rst ? '0 : r_count;
    w_full      = (w_count_eff == c_CNT_MAX);
    w_empty     = (r_count == '0);
    w_gnt       = data_req_i & mem_gnt_i & ~w_full;
    w_push      = data_req_i & w_gnt;
    // A response with nothing tracked is never matched to a same-cycle push.
    w_pop       = mem_r_valid_i & ~w_empty;
    w_spurious  = mem_r_valid_i & w_empty;
  end

  assign data_gnt_o  = w_gnt;
  assign mem_req_o   = data_req_i & ~w_full;
  assign mem_add_o   = data_add_i;
  assign mem_wen_o   = data_wen_i;
  assign mem_wdata_o = data_wdata_i;
  assign mem_be_o    = data_be_i;

  // Write the requester ID of each granted transfer into the tracking FIFO
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_id_fifo[r_wr_ptr] <= data_ID_i;
    end
  end

  // Pointer and occupancy update; pointers wrap explicitly for any depth
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // One-cycle response pulse carrying the head ID and the sampled slave data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_pop;
      if (w_pop) begin
        r_rsp_id    <= r_id_fifo[r_rd_ptr];
        r_rsp_rdata <= mem_r_rdata_i;
      end
    end
  end

  // Sticky flag for a slave response that had no tracked transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_spurious) begin
      r_err <= 1'b1;
    end
  end

  assign data_r_valid_o = r_rsp_valid;
  assign data_r_ID_o    = r_rsp_id;
  assign data_r_rdata_o = r_rsp_rdata;
  assign outstanding_o  = r_count;
  assign err_o          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bridge_resp_target.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bridge_resp_target
//  Purpose  : Directed self-checking bench for bridge_resp_target
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bridge_resp_target;

  localparam int c_AW = 32;
  localparam int c_DW = 32;
  localparam int c_BW = 4;
  localparam int c_IW = 16;
  localparam int c_MO = 4;
  localparam int c_CW = $clog2(c_MO + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            data_req_i;
  logic [c_AW-1:0] data_add_i;
  logic            data_wen_i;
  logic [c_DW-1:0] data_wdata_i;
  logic [c_BW-1:0] data_be_i;
  logic [c_IW-1:0] data_ID_i;
  logic            data_gnt_o;
  logic            data_r_valid_o;
  logic [c_IW-1:0] data_r_ID_o;
  logic [c_DW-1:0] data_r_rdata_o;
  logic            mem_req_o;
  logic [c_AW-1:0] mem_add_o;
  logic            mem_wen_o;
  logic [c_DW-1:0] mem_wdata_o;
  logic [c_BW-1:0] mem_be_o;
  logic            mem_gnt_i;
  logic            mem_r_valid_i;
  logic [c_DW-1:0] mem_r_rdata_i;
  logic [c_CW-1:0] outstanding_o;
  logic            err_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bridge_resp_target #(
    .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .BE_WIDTH(c_BW),
    .ID_WIDTH(c_IW), .MAX_OUTSTANDING(c_MO)
  ) u_dut (
    .clk(clk), .rst(rst),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_ID_i(data_ID_i),
    .data_gnt_o(data_gnt_o), .data_r_valid_o(data_r_valid_o),
    .data_r_ID_o(data_r_ID_o), .data_r_rdata_o(data_r_rdata_o),
    .mem_req_o(mem_req_o), .mem_add_o(mem_add_o), .mem_wen_o(mem_wen_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_r_valid_i(mem_r_valid_i), .mem_r_rdata_i(mem_r_rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic req, input logic [c_IW-1:0] id, input logic wen,
                         input logic gnt);
    data_req_i   = req;
    data_ID_i    = id;
    data_wen_i   = wen;
    data_add_i   = 32'h1000_0000 | {16'h0, id};
    data_wdata_i = 32'h5A00_0000 | {16'h0, id};
    data_be_i    = 4'hF;
    mem_gnt_i    = gnt;
  endtask

  task automatic set_rsp(input logic v, input logic [c_DW-1:0] rd);
    mem_r_valid_i = v;
    mem_r_rdata_i = rd;
  endtask

  // Granted push of one ID, one cycle
  task automatic push_id(input logic [c_IW-1:0] id);
    set_req(1'b1, id, 1'b0, 1'b1);
    #1;
    chk("push_gnt", {63'h0, data_gnt_o}, 64'h1);
    cyc();
    set_req(1'b0, '0, 1'b0, 1'b0);
  endtask

  logic [c_IW-1:0] exp_ids [4];

  initial begin
    rst = 1'b1;
    set_req(1'b0, '0, 1'b0, 1'b0);
    set_rsp(1'b0, '0);
    cyc();
    cyc();
    // ---------------- reset state ----------------
    chk("rst_outstanding", 64'(outstanding_o), 64'h0);
    chk("rst_r_valid", {63'h0, data_r_valid_o}, 64'h0);
    chk("rst_r_id", 64'(data_r_ID_o), 64'h0);
    chk("rst_r_rdata", 64'(data_r_rdata_o), 64'h0);
    chk("rst_err", {63'h0, err_o}, 64'h0);
    rst = 1'b0;
    cyc();

    // ---------------- single read ----------------
    set_req(1'b1, 16'h0004, 1'b1, 1'b1);
    #1;
    chk("rd_gnt", {63'h0, data_gnt_o}, 64'h1);
    chk("rd_mem_req", {63'h0, mem_req_o}, 64'h1);
    chk("rd_mem_add", 64'(mem_add_o), 64'h1000_0004);
    chk("rd_mem_wen", {63'h0, mem_wen_o}, 64'h1);
    chk("rd_mem_wdata", 64'(mem_wdata_o), 64'h5A00_0004);
    chk("rd_mem_be", 64'(mem_be_o), 64'hF);
    cyc();
    set_req(1'b0, '0, 1'b0, 1'b0);
    chk("rd_outst_1", 64'(outstanding_o), 64'h1);
    cyc();
    cyc();
    set_rsp(1'b1, 32'hDEAD_BEEF);
    chk("rd_no_early_rvalid", {63'h0, data_r_valid_o}, 64'h0);
    cyc();
    set_rsp(1'b0, '0);
    chk("rd_r_valid", {63'h0, data_r_valid_o}, 64'h1);
    chk("rd_r_id", 64'(data_r_ID_o), 64'h0004);
    chk("rd_r_rdata", 64'(data_r_rdata_o), 64'hDEAD_BEEF);
    chk("rd_outst_0", 64'(outstanding_o), 64'h0);
    cyc();
    chk("rd_pulse_end", {63'h0, data_r_valid_o}, 64'h0);
    chk("rd_id_hold", 64'(data_r_ID_o), 64'h0004);
    chk("rd_rdata_hold", 64'(data_r_rdata_o), 64'hDEAD_BEEF);

    // ---------------- fill to full ----------------
    exp_ids[0] = 16'h0001; exp_ids[1] = 16'h0002;
    exp_ids[2] = 16'h0004; exp_ids[3] = 16'h0008;
    for (int i = 0; i < 4; i++) push_id(exp_ids[i]);
    chk("full_outst", 64'(outstanding_o), 64'h4);
    set_req(1'b1, 16'h0010, 1'b0, 1'b1);
    #1;
    chk("full_gnt", {63'h0, data_gnt_o}, 64'h0);
    chk("full_mem_req", {63'h0, mem_req_o}, 64'h0);
    cyc();
    set_req(1'b0, '0, 1'b0, 1'b0);
    chk("full_no_push", 64'(outstanding_o), 64'h4);
    for (int i = 0; i < 4; i++) begin
      set_rsp(1'b1, 32'h100 + 32'(i));
      cyc();
      chk("full_drain_valid", {63'h0, data_r_valid_o}, 64'h1);
      chk("full_drain_id", 64'(data_r_ID_o), 64'(exp_ids[i]));
      chk("full_drain_rdata", 64'(data_r_rdata_o), 64'h100 + 64'(i));
    end
    set_rsp(1'b0, '0);
    chk("full_drained", 64'(outstanding_o), 64'h0);

    // ---------------- simultaneous push and pop ----------------
    push_id(16'h0010);
    push_id(16'h0020);
    set_req(1'b1, 16'h0040, 1'b0, 1'b1);
    set_rsp(1'b1, 32'h0000_00A5);
    #1;
    chk("pp_gnt", {63'h0, data_gnt_o}, 64'h1);
    cyc();
    set_req(1'b0, '0, 1'b0, 1'b0);
    set_rsp(1'b0, '0);
    chk("pp_outst", 64'(outstanding_o), 64'h2);
    chk("pp_r_id", 64'(data_r_ID_o), 64'h0010);
    push_id(16'h0080);
    push_id(16'h0100);
    chk("pp_full", 64'(outstanding_o), 64'h4);
    set_req(1'b1, 16'h0200, 1'b0, 1'b1);
    set_rsp(1'b1, 32'h0000_00B6);
    #1;
    chk("pp_full_pop_gnt", {63'h0, data_gnt_o}, 64'h0);
    cyc();
    set_rsp(1'b0, '0);
    chk("pp_full_pop_id", 64'(data_r_ID_o), 64'h0020);
    chk("pp_full_pop_outst", 64'(outstanding_o), 64'h3);
    #1;
    chk("pp_next_gnt", {63'h0, data_gnt_o}, 64'h1);
    cyc();
    set_req(1'b0, '0, 1'b0, 1'b0);
    chk("pp_refull", 64'(outstanding_o), 64'h4);
    exp_ids[0] = 16'h0040; exp_ids[1] = 16'h0080;
    exp_ids[2] = 16'h0100; exp_ids[3] = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      set_rsp(1'b1, 32'h200 + 32'(i));
      cyc();
      chk("pp_drain_id", 64'(data_r_ID_o), 64'(exp_ids[i]));
    end
    set_rsp(1'b0, '0);
    chk("pp_drained", 64'(outstanding_o), 64'h0);

    // ---------------- slave stall ----------------
    set_req(1'b1, 16'h0008, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_gnt", {63'h0, data_gnt_o}, 64'h0);
      chk("stall_mem_req", {63'h0, mem_req_o}, 64'h1);
      cyc();
    end
    chk("stall_no_push", 64'(outstanding_o), 64'h0);
    mem_gnt_i = 1'b1;
    #1;
    chk("stall_gnt_go", {63'h0, data_gnt_o}, 64'h1);
    cyc();
    set_req(1'b0, '0, 1'b0, 1'b0);
    chk("stall_one_push", 64'(outstanding_o), 64'h1);
    set_rsp(1'b1, 32'h0BAD_F00D);
    cyc();
    set_rsp(1'b0, '0);
    chk("stall_rsp_id", 64'(data_r_ID_o), 64'h0008);
    chk("stall_rsp_rdata", 64'(data_r_rdata_o), 64'h0BAD_F00D);

    // ---------------- spurious response ----------------
    chk("spur_err_before", {63'h0, err_o}, 64'h0);
    set_rsp(1'b1, 32'h0000_1234);
    cyc();
    set_rsp(1'b0, '0);
    chk("spur_no_rvalid", {63'h0, data_r_valid_o}, 64'h0);
    chk("spur_err", {63'h0, err_o}, 64'h1);
    chk("spur_outst", 64'(outstanding_o), 64'h0);
    // push and response together at count 0: no pop, new ID stays tracked
    set_req(1'b1, 16'h0002, 1'b0, 1'b1);
    set_rsp(1'b1, 32'h0000_5678);
    cyc();
    set_req(1'b0, '0, 1'b0, 1'b0);
    set_rsp(1'b0, '0);
    chk("spur_push_no_rvalid", {63'h0, data_r_valid_o}, 64'h0);
    chk("spur_push_outst", 64'(outstanding_o), 64'h1);
    cyc();
    chk("spur_err_sticky", {63'h0, err_o}, 64'h1);
    set_rsp(1'b1, 32'h0000_9ABC);
    cyc();
    set_rsp(1'b0, '0);
    chk("spur_later_id", 64'(data_r_ID_o), 64'h0002);
    chk("spur_later_valid", {63'h0, data_r_valid_o}, 64'h1);

    // ---------------- reset mid-flight ----------------
    push_id(16'h0001);
    push_id(16'h0002);
    push_id(16'h0004);
    chk("mid_outst", 64'(outstanding_o), 64'h3);
    set_rsp(1'b1, 32'h7777_7777);
    cyc();
    set_rsp(1'b0, '0);
    chk("mid_inflight_valid", {63'h0, data_r_valid_o}, 64'h1);
    rst = 1'b1;
    set_req(1'b1, 16'h0800, 1'b0, 1'b1);
    #1;
    chk("mid_rst_gnt", {63'h0, data_gnt_o}, 64'h1);
    cyc();
    rst = 1'b0;
    set_req(1'b0, '0, 1'b0, 1'b0);
    chk("mid_rst_outst", 64'(outstanding_o), 64'h0);
    chk("mid_rst_rvalid", {63'h0, data_r_valid_o}, 64'h0);
    chk("mid_rst_err", {63'h0, err_o}, 64'h0);
    chk("mid_rst_rid", 64'(data_r_ID_o), 64'h0);
    push_id(16'h0040);
    chk("mid_new_outst", 64'(outstanding_o), 64'h1);
    set_rsp(1'b1, 32'h0000_CAFE);
    cyc();
    set_rsp(1'b0, '0);
    chk("mid_new_id", 64'(data_r_ID_o), 64'h0040);
    chk("mid_new_rdata", 64'(data_r_rdata_o), 64'h0000_CAFE);
    chk("mid_new_err", {63'h0, err_o}, 64'h0);
    // stale slave response after reset is flagged
    set_rsp(1'b1, 32'h0000_0001);
    cyc();
    set_rsp(1'b0, '0);
    chk("stale_err", {63'h0, err_o}, 64'h1);
    chk("stale_no_rvalid", {63'h0, data_r_valid_o}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bridge_resp_target.md
Name: bridge_resp_target

Overview:
- Target-side end of the bridge req/gnt protocol.
- Accepts a single arbitrated request stream, for example the output of the bridge request block, and forwards it to a memory/slave port that has variable response latency.
- Tracks the requester ID of every outstanding transaction in order, and generates the push-style response (r_valid, r_ID, r_rdata) that the initiator side decodes back to its masters.

Parameters:
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 32, write/read data width
BE_WIDTH, DATA_WIDTH/8, byte-enable width
ID_WIDTH, 16, requester ID width (one-hot master ID on the initiator side)
MAX_OUTSTANDING, 4, depth of the in-order ID tracking FIFO; must be >=1, need not be a power of 2

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
data_req_i  in  1  request valid
data_add_i  in  ADDR_WIDTH  address
data_wen_i  in  1  1 = read, 0 = write
data_wdata_i  in  DATA_WIDTH  write data
data_be_i  in  BE_WIDTH  byte enables
data_ID_i  in  ID_WIDTH  requester ID
data_gnt_o  out  1  request accepted this cycle
data_r_valid_o  out  1  response valid; single-cycle pulse; there is no back-pressure
data_r_ID_o  out  ID_WIDTH  ID of the responding transaction
data_r_rdata_o  out  DATA_WIDTH  read data; for writes it carries whatever the slave returns
mem_req_o  out  1  slave request
mem_add_o  out  ADDR_WIDTH  slave address
mem_wen_o  out  1  slave read/write
mem_wdata_o  out  DATA_WIDTH  slave write data
mem_be_o  out  BE_WIDTH  slave byte enables
mem_gnt_i  in  1  slave grant
mem_r_valid_i  in  1  slave response; in order; issued for both reads and writes
mem_r_rdata_i  in  DATA_WIDTH  slave read data
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current number of tracked transactions
err_o  out  1  sticky: a response arrived with nothing outstanding

Behaviour:
Clocking and reset
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: data_r_valid_o=0, data_r_ID_o=0, data_r_rdata_o=0, outstanding_o=0, err_o=0. FIFO pointers are cleared.

Request path (combinational)
- full = (count == MAX_OUTSTANDING), using the registered count only.
- mem_req_o = data_req_i & ~full.
- mem_add_o, mem_wen_o, mem_wdata_o, mem_be_o pass through data_* unchanged.
- data_gnt_o = data_req_i & mem_gnt_i & ~full.
- While full, gnt stays low even if a pop happens in the same cycle. A freed slot is usable from the next cycle. This is deliberate: it keeps gnt off the r_valid path.
- Handshake: a transfer happens in any cycle where data_req_i & data_gnt_o. The initiator holds req and payload stable until gnt. This block never stores payload; it only stores the ID.

ID FIFO
- push = data_req_i & data_gnt_o: write data_ID_i at the write pointer.
- pop = mem_r_valid_i & (count != 0): read the head.
- Pointers wrap modulo MAX_OUTSTANDING, which also covers non-power-of-2 depths.
- count update:
  - +1 on push only
  - -1 on pop only
  - unchanged when push and pop occur together; this is legal whenever count is between 1 and MAX_OUTSTANDING-1
- When count == 0, a push and a mem_r_valid_i in the same cycle do not pop. That response is an error (see below); it is never matched to the new ID.
- outstanding_o = count (registered).

Response path (registered, latency 1 from mem_r_valid_i)
- On a pop, the next cycle gives:
  - data_r_valid_o = 1
  - data_r_ID_o = FIFO head
  - data_r_rdata_o = mem_r_rdata_i as sampled
- Otherwise data_r_valid_o = 0 and data_r_ID_o / data_r_rdata_o hold their last values.
- Back-to-back mem_r_valid_i cycles give back-to-back data_r_valid_o pulses.
- mem_r_valid_i with count == 0:
  - no response is produced
  - err_o is set and stays set until rst

Reset mid-operation
- All tracked IDs are discarded, and a response in flight from the previous cycle is not emitted after rst.
- The slave must be reset together with this block. A stale response arriving after reset sets err_o.
- While rst is high, outputs are held at their reset values and data_gnt_o follows the combinational rule with count = 0.

Test Plan:
- Single read: req with ID=0x0004 and mem_gnt_i=1 gives gnt the same cycle. mem_r_valid_i three cycles later with rdata=0xDEADBEEF gives, one cycle after that, r_valid=1, r_ID=0x0004, r_rdata=0xDEADBEEF; outstanding goes 0→1→0.
- Fill to full: MAX_OUTSTANDING=4, four granted writes with IDs 1,2,4,8 and no responses. The 5th req sees gnt=0 and mem_req_o=0. Four mem_r_valid_i pulses then return IDs 1,2,4,8 in order on consecutive cycles.
- Simultaneous push and pop at count=2: count stays 2, and the head ID is returned while the new ID is appended. At count=4 with a pop the same cycle, gnt=0; gnt=1 the following cycle.
- Slave stall: req held with mem_gnt_i=0 for 5 cycles gives no gnt and no push. On the cycle mem_gnt_i=1, exactly one push occurs.
- Spurious response: mem_r_valid_i at count=0 gives no r_valid and err_o=1, which persists until rst.
- Reset mid-flight: 3 outstanding, then rst for 1 cycle. Result is outstanding_o=0, r_valid=0, err_o=0, and a new request/response pair afterwards returns the new ID correctly.
